// File: rtl/audio_sample_player.sv
// audio_sample_player
//   Buffers 8-bit unsigned audio samples in a small FIFO, releases one
//   sample per SAMPLE_DIV clock cycles, and renders the current sample as
//   an 8-bit PWM waveform. A period is 256 clocks, and the duty cycle is
//   only ever updated on a period boundary.
//
// Ports
//   clk           system clock, rising edge
//   system_reset  asynchronous active-low reset
//   enable        releases sample pacing and the PWM counter
//   s_data        sample input (0x80 = mid-scale)
//   s_valid       s_data valid
//   s_ready       FIFO has room (combinational)
//   clr_underrun  synchronous clear of the sticky underrun flag
//   underrun      sticky: a sample tick found the FIFO empty
//   fifo_level    number of stored samples
//   PWM_out       registered PWM audio output
module audio_sample_player #(
  parameter int unsigned SAMPLE_DIV = 12500,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          system_reset,
  input  logic                          enable,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          clr_underrun,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          PWM_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]    cur_sample_q, cur_sample_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          pwm_q, pwm_d;

  logic push, pop, tick, empty;

  always_comb begin
    s_ready    = (level_q < LVL_FULL);
    fifo_level = level_q;
    underrun   = underrun_q;
    PWM_out    = pwm_q;
  end

  always_comb begin
    empty = (level_q == '0);
    push  = s_valid & s_ready;
    tick  = enable & (div_cnt_q == DIV_LAST);
    pop   = tick & ~empty;

    div_cnt_d = '0;
    if (enable) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A push into an empty FIFO on a tick is not forwarded: the tick
    // underruns and the sample waits for the next tick.
    cur_sample_d = pop ? mem_q[rd_ptr_q] : cur_sample_q;

    // Setting on an empty tick takes priority over a coincident clear.
    underrun_d = underrun_q;
    if (tick & empty) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end

    pwm_cnt_d = enable ? pwm_cnt_q + 1'b1 : '0;
    duty_d    = (pwm_cnt_q == 8'hFF) ? cur_sample_q : duty_q;
    pwm_d     = enable & (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      div_cnt_q    <= '0;
      cur_sample_q <= 8'h80;
      underrun_q   <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_q       <= 8'h80;
      pwm_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      div_cnt_q    <= div_cnt_d;
      cur_sample_q <= cur_sample_d;
      underrun_q   <= underrun_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// tb_audio_sample_player
//   Scoreboarded bench for audio_sample_player with SAMPLE_DIV=16 and
//   FIFO_DEPTH=4. Accepted pushes are queued with the edge they landed on;
//   a monitor pops the queue on each sample tick and compares the played
//   sample, the underrun flag and the FIFO level.
module tb_audio_sample_player;

  localparam int SD = 16;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       system_reset;
  logic       enable;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       clr_underrun;
  logic       underrun;
  logic [2:0] fifo_level;
  logic       PWM_out;

  always #5 clk = ~clk;

  audio_sample_player #(
    .SAMPLE_DIV(SD),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .PWM_out      (PWM_out)
  );

  logic [7:0] cur;
  assign cur = dut.cur_sample_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_pop;
  int         cyc      = 0;
  int         m_cnt    = 0;
  bit         m_ticked = 1'b0;
  int         m_pwm    = 0;
  bit         pend     = 1'b0;
  logic [7:0] pend_data = '0;
  logic [7:0] last_cur = 8'h80;

  // Handshake seen between edges; committed to the scoreboard on the edge.
  always @(negedge clk) begin
    pend      <= s_valid && s_ready;
    pend_data <= s_data;
  end

  // Reference pacing and PWM counters; each accepted push is tagged with
  // the edge number it landed on.
  always @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      m_cnt    <= 0;
      m_ticked <= 1'b0;
      m_pwm    <= 0;
      exp_q.delete();
    end else begin
      cyc      <= cyc + 1;
      m_ticked <= enable && (m_cnt == SD - 1);
      m_cnt    <= enable ? ((m_cnt == SD - 1) ? 0 : m_cnt + 1) : 0;
      m_pwm    <= enable ? ((m_pwm + 1) % 256) : 0;
      if (pend) exp_q.push_back('{pend_data, cyc + 1});
    end
  end

  // Only samples pushed on an earlier edge may be played on a tick.
  always @(negedge clk) begin
    if (!system_reset) begin
      last_cur <= 8'h80;
    end else if (m_ticked) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e_pop = exp_q.pop_front();
        check("tick_sample", cur, e_pop.data);
        last_cur <= e_pop.data;
      end else begin
        check("tick_underrun", underrun, 1);
        check("tick_hold", cur, last_cur);
      end
      check("tick_level", fifo_level, exp_q.size());
    end else begin
      check("hold_between_ticks", cur, last_cur);
    end
  end

  task automatic push(input logic [7:0] d, output int acc);
    bit r;
    acc     = -1;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    s_valid = 1'b0;
    if (acc < 0) check("push_timeout", 0, 1);
  endtask

  // High cycles over one PWM period aligned to the counter boundary.
  task automatic measure(output int hi);
    bit found;
    found = 1'b0;
    hi    = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (m_pwm == 1) found = 1'b1;
    end
    if (!found) begin
      check("pwm_sync_timeout", 0, 1);
    end else begin
      hi = int'(PWM_out);
      for (int i = 1; i < 256; i++) begin
        @(negedge clk);
        hi += int'(PWM_out);
      end
    end
  endtask

  task automatic feed(input logic [7:0] v);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    s_data  = v;
    s_valid = 1'b1;
  endtask

  logic [7:0] fill_v [4];
  int acc, c0, hi;
  bit found;

  initial begin
    fill_v = '{8'h10, 8'h20, 8'h30, 8'h40};
    system_reset = 1'b0;
    enable       = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    clr_underrun = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_pwm", PWM_out, 0);
    check("rst_cur_sample", cur, 8'h80);
    #3 system_reset = 1'b1;
    @(posedge clk); #1;

    // Fill while paused
    foreach (fill_v[i]) push(fill_v[i], acc);
    check("fill_level", fifo_level, 4);
    check("fill_s_ready", s_ready, 0);

    // Fifth push is held until the first tick frees a slot
    c0     = cyc;
    enable = 1'b1;
    push(8'h50, acc);
    check("fifth_push_edge", acc, c0 + 17);

    while (cyc < c0 + 100) begin
      @(posedge clk); #1;
    end
    check("drain_underrun", underrun, 1);
    check("drain_cur_hold", cur, 8'h50);
    check("drain_level", fifo_level, 0);

    clr_underrun = 1'b1;
    @(posedge clk); #1;
    clr_underrun = 1'b0;
    check("clr_underrun", underrun, 0);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_cnt == SD - 1) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("tick_found", found, 1);
    clr_underrun = 1'b1;
    @(posedge clk); #1;
    clr_underrun = 1'b0;
    check("clr_vs_set", underrun, 1);

    // Duty: steady 0x00 then 0x80
    s_data  = 8'h00;
    s_valid = 1'b1;
    repeat (400) @(posedge clk);
    measure(hi); check("duty00_p0", hi, 0);
    measure(hi); check("duty00_p1", hi, 0);

    feed(8'h80);
    repeat (400) @(posedge clk);
    measure(hi); check("duty80_p0", hi, 128);
    measure(hi); check("duty80_p1", hi, 128);

    // 0x80 -> 0xFF: every aligned period holds one duty or the other
    feed(8'hFF);
    for (int k = 0; k < 4; k++) begin
      measure(hi);
      if (k < 2) check("duty_no_mid_change", (hi == 128 || hi == 255), 1);
      else       check("dutyFF", hi, 255);
    end

    // Reset mid-playback
    @(posedge clk); #1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!s_ready) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("prefill_full", found, 1);
    s_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (fifo_level == 3 && PWM_out) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("pre_reset_level", fifo_level, 3);
    check("pre_reset_pwm", PWM_out, 1);
    #1 system_reset = 1'b0;
    #1;
    check("async_rst_pwm", PWM_out, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_s_ready", s_ready, 1);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_cur", cur, 8'h80);
    repeat (2) @(posedge clk);
    #4 system_reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_underrun", underrun, 0);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_first_tick_underrun", underrun, 1);
    check("post_rst_cur", cur, 8'h80);
    check("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
